// File: rtl/fwd_hazard_unit_if.sv
// Issue/hazard bundle between the ID stage and fwd_hazard_unit.
// Optional stall counter signal exists only when FWD_STALL_CNT_EN is defined.
interface fwd_hazard_unit_if #(
    parameter int ADDR_W = 2
`ifdef FWD_STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [ADDR_W-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              mem_busy;
    logic              flush;
    logic              stall_if_id;
    logic              bubble_ex;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    // Pipeline side: presents issue info, consumes stall/forward controls
    modport master (
`ifdef FWD_STALL_CNT_EN
        input  stall_cnt,
`endif
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        output id_rd, id_reg_write, id_mem_read, mem_busy, flush,
        input  stall_if_id, bubble_ex, fwd_a, fwd_b
    );

    // Hazard unit side
    modport slave (
`ifdef FWD_STALL_CNT_EN
        output stall_cnt,
`endif
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        input  id_rd, id_reg_write, id_mem_read, mem_busy, flush,
        output stall_if_id, bubble_ex, fwd_a, fwd_b
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard controller with an internal shadow pipeline
// (EX, then MEM/WB/WB1 holding only {v,rd,wr}) fed from ID issue info.
// Optional feature macro: FWD_STALL_CNT_EN adds a saturating stall counter.
module fwd_hazard_unit #(
    parameter int ADDR_W   = 2,
    parameter int NUM_FWD  = 2,
    parameter int ZERO_REG = 0
`ifdef FWD_STALL_CNT_EN
    , parameter int CNT_W  = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    fwd_hazard_unit_if.slave bus
);
    // Only the stages that can be forward sources are kept.
    localparam int NS = NUM_FWD;

    logic              ex_v_reg, ex_rs_used_reg, ex_rt_used_reg, ex_wr_reg, ex_ld_reg;
    logic [ADDR_W-1:0] ex_rs_reg, ex_rt_reg, ex_rd_reg;

    // Index 1 = MEM, 2 = WB, 3 = WB1; the index is also the forward select code.
    logic [NS:1]       bk_v_reg;
    logic [NS:1]       bk_wr_reg;
    logic [ADDR_W-1:0] bk_rd_reg [1:NS];

    logic       lu, kill_ex, stall_int, bubble_int;
    logic [NS:1] hit_a, hit_b;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    function automatic logic src_match(input logic v, input logic wr,
                                       input logic [ADDR_W-1:0] rd,
                                       input logic [ADDR_W-1:0] r);
        return v && wr && (rd == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    assign lu = ex_v_reg && ex_ld_reg && bus.id_valid &&
                ((bus.id_rs_used && src_match(ex_v_reg, ex_wr_reg, ex_rd_reg, bus.id_rs)) ||
                 (bus.id_rt_used && src_match(ex_v_reg, ex_wr_reg, ex_rd_reg, bus.id_rt)));

    // A flush outranks a load-use; both turn the ID instruction into an EX bubble.
    assign kill_ex = bus.flush || lu;

    // Outputs are forced low while reset is held so a pending stall drops immediately.
    assign stall_int  = reset_n && (bus.mem_busy || (!bus.flush && lu));
    assign bubble_int = reset_n && !bus.mem_busy && kill_ex;

    genvar gi;
    generate
        for (gi = 1; gi <= NS; gi++) begin : g_src
            assign hit_a[gi] = ex_v_reg && ex_rs_used_reg &&
                               src_match(bk_v_reg[gi], bk_wr_reg[gi], bk_rd_reg[gi], ex_rs_reg);
            assign hit_b[gi] = ex_v_reg && ex_rt_used_reg &&
                               src_match(bk_v_reg[gi], bk_wr_reg[gi], bk_rd_reg[gi], ex_rt_reg);
        end
    endgenerate

    // Nearest matching stage wins: scan far-to-near so the nearest hit is written last.
    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        for (int i = NS; i >= 1; i--) begin
            if (hit_a[i]) fwd_a_sel = 2'(i);
            if (hit_b[i]) fwd_b_sel = 2'(i);
        end
    end

    assign bus.stall_if_id = stall_int;
    assign bus.bubble_ex   = bubble_int;
    assign bus.fwd_a       = fwd_a_sel;
    assign bus.fwd_b       = fwd_b_sel;

    // Shadow pipeline advance: frozen on mem_busy, EX takes ID or a bubble otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_v_reg       <= 1'b0;
            ex_rs_reg      <= '0;
            ex_rt_reg      <= '0;
            ex_rs_used_reg <= 1'b0;
            ex_rt_used_reg <= 1'b0;
            ex_rd_reg      <= '0;
            ex_wr_reg      <= 1'b0;
            ex_ld_reg      <= 1'b0;
            for (int i = 1; i <= NS; i++) begin
                bk_v_reg[i]  <= 1'b0;
                bk_wr_reg[i] <= 1'b0;
                bk_rd_reg[i] <= '0;
            end
        end else if (!bus.mem_busy) begin
            ex_v_reg       <= bus.id_valid && !kill_ex;
            ex_rs_reg      <= bus.id_rs;
            ex_rt_reg      <= bus.id_rt;
            ex_rs_used_reg <= bus.id_rs_used;
            ex_rt_used_reg <= bus.id_rt_used;
            ex_rd_reg      <= bus.id_rd;
            ex_wr_reg      <= bus.id_reg_write;
            ex_ld_reg      <= bus.id_mem_read;
            bk_v_reg[1]    <= ex_v_reg;
            bk_wr_reg[1]   <= ex_wr_reg;
            bk_rd_reg[1]   <= ex_rd_reg;
            for (int i = 2; i <= NS; i++) begin
                bk_v_reg[i]  <= bk_v_reg[i-1];
                bk_wr_reg[i] <= bk_wr_reg[i-1];
                bk_rd_reg[i] <= bk_rd_reg[i-1];
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    // Count every cycle IF/ID is held, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_reg <= '0;
        else if (stall_int && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign bus.stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized + directed bench for fwd_hazard_unit. Three instances share one
// stimulus stream: (NUM_FWD=2,ZERO_REG=0), (1,0), (3,1, small counter).
// Reference model keeps an age-ordered history of issued instructions.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, mem_busy, flush;
    logic [1:0] id_rs, id_rt, id_rd;

    fwd_hazard_unit_if #(.ADDR_W(2)
`ifdef FWD_STALL_CNT_EN
        , .CNT_W(16)
`endif
    ) bus0 ();
    fwd_hazard_unit_if #(.ADDR_W(2)
`ifdef FWD_STALL_CNT_EN
        , .CNT_W(16)
`endif
    ) bus1 ();
    fwd_hazard_unit_if #(.ADDR_W(2)
`ifdef FWD_STALL_CNT_EN
        , .CNT_W(2)
`endif
    ) bus2 ();

    fwd_hazard_unit #(.ADDR_W(2), .NUM_FWD(2), .ZERO_REG(0)
`ifdef FWD_STALL_CNT_EN
        , .CNT_W(16)
`endif
    ) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    fwd_hazard_unit #(.ADDR_W(2), .NUM_FWD(1), .ZERO_REG(0)
`ifdef FWD_STALL_CNT_EN
        , .CNT_W(16)
`endif
    ) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
    fwd_hazard_unit #(.ADDR_W(2), .NUM_FWD(3), .ZERO_REG(1)
`ifdef FWD_STALL_CNT_EN
        , .CNT_W(2)
`endif
    ) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    // Fan the shared stimulus out to every instance
    assign {bus0.id_valid, bus1.id_valid, bus2.id_valid} = {3{id_valid}};
    assign {bus0.id_rs, bus1.id_rs, bus2.id_rs} = {3{id_rs}};
    assign {bus0.id_rt, bus1.id_rt, bus2.id_rt} = {3{id_rt}};
    assign {bus0.id_rs_used, bus1.id_rs_used, bus2.id_rs_used} = {3{id_rs_used}};
    assign {bus0.id_rt_used, bus1.id_rt_used, bus2.id_rt_used} = {3{id_rt_used}};
    assign {bus0.id_rd, bus1.id_rd, bus2.id_rd} = {3{id_rd}};
    assign {bus0.id_reg_write, bus1.id_reg_write, bus2.id_reg_write} = {3{id_reg_write}};
    assign {bus0.id_mem_read, bus1.id_mem_read, bus2.id_mem_read} = {3{id_mem_read}};
    assign {bus0.mem_busy, bus1.mem_busy, bus2.mem_busy} = {3{mem_busy}};
    assign {bus0.flush, bus1.flush, bus2.flush} = {3{flush}};

    logic       obs_stall [3];
    logic       obs_bub   [3];
    logic [1:0] obs_fa    [3];
    logic [1:0] obs_fb    [3];
    assign obs_stall[0] = bus0.stall_if_id; assign obs_stall[1] = bus1.stall_if_id; assign obs_stall[2] = bus2.stall_if_id;
    assign obs_bub[0]   = bus0.bubble_ex;   assign obs_bub[1]   = bus1.bubble_ex;   assign obs_bub[2]   = bus2.bubble_ex;
    assign obs_fa[0]    = bus0.fwd_a;       assign obs_fa[1]    = bus1.fwd_a;       assign obs_fa[2]    = bus2.fwd_a;
    assign obs_fb[0]    = bus0.fwd_b;       assign obs_fb[1]    = bus1.fwd_b;       assign obs_fb[2]    = bus2.fwd_b;
`ifdef FWD_STALL_CNT_EN
    int obs_cnt [3];
    assign obs_cnt[0] = int'(bus0.stall_cnt);
    assign obs_cnt[1] = int'(bus1.stall_cnt);
    assign obs_cnt[2] = int'(bus2.stall_cnt);
`endif

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [1:0] rs, rt;
        logic       rsu, rtu;
        logic [1:0] rd;
        logic       wr, ld;
    } ins_t;

    ins_t hist [3][4];            // [instance][age]: age 0 = EX, 1 = MEM, 2 = WB, 3 = WB1
    int   nf   [3] = '{2, 1, 3};
    int   zr   [3] = '{0, 0, 1};
    int   cmax [3] = '{65535, 65535, 3};
    int   mcnt [3];
    bit   exp_lu [3];
    bit   exp_stall [3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic bit writes(input ins_t s, input logic [1:0] r, input int k);
        return s.v && s.wr && (s.rd == r) && !(zr[k] != 0 && r == 2'd0);
    endfunction

    // Select code = age of the youngest older producer within reach, 0 if none
    function automatic int exp_fwd(input int k, input logic used, input logic [1:0] r);
        if (!(hist[k][0].v && used)) return 0;
        for (int d = 1; d <= nf[k]; d++)
            if (writes(hist[k][d], r, k)) return d;
        return 0;
    endfunction

    function automatic ins_t cur_id();
        ins_t t;
        t.v = id_valid; t.rs = id_rs; t.rt = id_rt; t.rsu = id_rs_used; t.rtu = id_rt_used;
        t.rd = id_rd; t.wr = id_reg_write; t.ld = id_mem_read;
        return t;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            for (int d = 0; d < 4; d++) hist[k][d] = '0;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                         input logic rsu, input logic rtu, input logic [1:0] rd,
                         input logic wr, input logic ld, input logic busy, input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_rd = rd; id_reg_write = wr; id_mem_read = ld; mem_busy = busy; flush = fl;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_model();
        ins_t e;
        bit   bub;
        for (int k = 0; k < 3; k++) begin
            e = hist[k][0];
            exp_lu[k] = e.v && e.ld && id_valid &&
                        ((id_rs_used && writes(e, id_rs, k)) || (id_rt_used && writes(e, id_rt, k)));
            exp_stall[k] = mem_busy || (!flush && exp_lu[k]);
            bub = !mem_busy && (flush || exp_lu[k]);
            chk($sformatf("i%0d_stall", k), int'(obs_stall[k]), int'(exp_stall[k]));
            chk($sformatf("i%0d_bubble", k), int'(obs_bub[k]), int'(bub));
            chk($sformatf("i%0d_fwd_a", k), int'(obs_fa[k]), exp_fwd(k, e.rsu, e.rs));
            chk($sformatf("i%0d_fwd_b", k), int'(obs_fb[k]), exp_fwd(k, e.rtu, e.rt));
`ifdef FWD_STALL_CNT_EN
            chk($sformatf("i%0d_cnt", k), obs_cnt[k], mcnt[k]);
`endif
        end
    endtask

    task automatic tick();
        ins_t nxt;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (exp_stall[k] && mcnt[k] < cmax[k]) mcnt[k]++;
            if (!mem_busy) begin
                for (int d = 3; d >= 1; d--) hist[k][d] = hist[k][d-1];
                nxt = cur_id();
                if (flush || exp_lu[k]) nxt = '0;
                hist[k][0] = nxt;
            end
        end
        #1;
    endtask

    task automatic step(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                        input logic rsu, input logic rtu, input logic [1:0] rd,
                        input logic wr, input logic ld, input logic busy, input logic fl);
        drive(v, rs, rt, rsu, rtu, rd, wr, ld, busy, fl);
        check_model();
        tick();
    endtask

    // Asserts reset wherever the run currently is, checks outputs drop at once
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_rst_stall%0d", tag, k), int'(obs_stall[k]), 0);
            chk($sformatf("%s_rst_bubble%0d", tag, k), int'(obs_bub[k]), 0);
            chk($sformatf("%s_rst_fwd_a%0d", tag, k), int'(obs_fa[k]), 0);
            chk($sformatf("%s_rst_fwd_b%0d", tag, k), int'(obs_fb[k]), 0);
`ifdef FWD_STALL_CNT_EN
            chk($sformatf("%s_rst_cnt%0d", tag, k), obs_cnt[k], 0);
`endif
        end
        idle();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] r_rs, r_rt, r_rd;
    logic       r_v, r_rsu, r_rtu, r_wr, r_ld, r_busy, r_fl;
    bit         hold;

    initial begin
        idle();
        model_clear();
        do_reset("init");

        // T2: MEM forward, then WB forward (out of reach for NUM_FWD=1)
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);          // add r1
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);          // reads r1
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("T2_mem_fwd_a", int'(obs_fa[0]), 1);
        chk("T2_mem_fwd_a_nf1", int'(obs_fa[1]), 1);
        tick();
        do_reset("T2b");
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("T2_wb_fwd_a", int'(obs_fa[0]), 2);
        chk("T2_wb_fwd_a_nf1", int'(obs_fa[1]), 0);
        tick();

        // T3: load-use on rt, one stall cycle, then WB forward
        do_reset("T3");
        step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);          // ld r2
        drive(1, 0, 2, 0, 1, 3, 1, 0, 0, 0); check_model();
        chk("T3_lu_stall", int'(obs_stall[0]), 1);
        chk("T3_lu_bubble", int'(obs_bub[0]), 1);
        tick();
        drive(1, 0, 2, 0, 1, 3, 1, 0, 0, 0); check_model();
        chk("T3_reissue_stall", int'(obs_stall[0]), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("T3_fwd_b", int'(obs_fb[0]), 2);
        tick();

        // T4: nearest producer wins; r0 ignored when ZERO_REG=1
        do_reset("T4");
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step(1, 3, 0, 1, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("T4_nearest", int'(obs_fa[0]), 1);
        tick();
        do_reset("T4z");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("T4_r0_zr0", int'(obs_fa[0]), 1);
        chk("T4_r0_zr1", int'(obs_fa[2]), 0);
        tick();

        // T5: load-use under a 3-cycle cache wait, then the lu bubble
        do_reset("T5");
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);          // ld r1
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 0, 2, 1, 0, 1, 0); check_model();
            chk("T5_busy_stall", int'(obs_stall[0]), 1);
            chk("T5_busy_bubble", int'(obs_bub[0]), 0);
            tick();
        end
        drive(1, 1, 0, 1, 0, 2, 1, 0, 0, 0); check_model();
        chk("T5_lu_bubble", int'(obs_bub[0]), 1);
        tick();
        drive(1, 1, 0, 1, 0, 2, 1, 0, 0, 0); check_model();
        chk("T5_release", int'(obs_stall[0]), 0);
`ifdef FWD_STALL_CNT_EN
        chk("T5_stall_cnt", obs_cnt[0], 4);
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("T5_fwd_a", int'(obs_fa[0]), 2);
        tick();

        // T6: flush coincident with load-use
        do_reset("T6");
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 1); check_model();
        chk("T6_stall", int'(obs_stall[0]), 0);
        chk("T6_bubble", int'(obs_bub[0]), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("T6_fwd_a", int'(obs_fa[0]), 0);
        chk("T6_fwd_b", int'(obs_fb[0]), 0);
        tick();

        // T1: reset asserted in the middle of a load-use stall
        do_reset("T1pre");
        step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        drive(1, 0, 2, 0, 1, 3, 1, 0, 0, 0); check_model();
        chk("T1_pre_stall", int'(obs_stall[0]), 1);
        #2;
        do_reset("T1");
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0); check_model();
        chk("T1_indep_fwd_a", int'(obs_fa[0]), 0);
        tick();

        // Randomized phase: ID held while the reference instance stalls
        do_reset("rand");
        hold = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!hold) begin
                r_v = ($urandom_range(3) != 0); r_rs = 2'($urandom_range(3)); r_rt = 2'($urandom_range(3));
                r_rsu = 1'($urandom_range(1)); r_rtu = 1'($urandom_range(1)); r_rd = 2'($urandom_range(3));
                r_wr = ($urandom_range(3) != 0); r_ld = ($urandom_range(2) == 0);
            end
            r_busy = ($urandom_range(7) == 0);
            r_fl   = ($urandom_range(9) == 0);
            drive(r_v, r_rs, r_rt, r_rsu, r_rtu, r_rd, r_wr, r_ld, r_busy, r_fl);
            check_model();
            hold = exp_stall[0];
            tick();
            if (n == 1000) do_reset("mid");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
